// File: rtl/lane_dram_if.sv
// Request/response bus between a lane memory client and lane_dram.
//   master: drives req_valid/req_we/req_en/req_addr/req_data and rsp_ready
//   slave : drives req_ready and rsp_valid/rsp_we/rsp_en/rsp_err/rsp_data
interface lane_dram_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) ();

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [LANES-1:0]          req_en;
  logic [LANES*ADDR_W-1:0]   req_addr;
  logic [LANES*DATA_W-1:0]   req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_we;
  logic [LANES-1:0]          rsp_en;
  logic [LANES-1:0]          rsp_err;
  logic [LANES*DATA_W-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_en, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_en, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_en, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_en, rsp_err, rsp_data
  );

endinterface

// File: rtl/lane_dram.sv
// Multi-lane DRAM behavioural model: one outstanding transaction, separate
// read/write latency, per-lane out-of-range error reporting.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; clears state, outputs and memory
//   bus   - lane_dram_if slave: valid/ready request in, valid/ready response out
module lane_dram #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 20,
  parameter int unsigned WR_LAT = 20
) (
  input  logic         clk,
  input  logic         reset,
  lane_dram_if.slave   bus
);

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int unsigned MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W   = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_req_ready;

  logic                      r_we;
  logic [LANES-1:0]          r_en;
  logic [LANES*ADDR_W-1:0]   r_addr;
  logic [LANES*DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_mem [DEPTH];

  logic                      r_rsp_valid;
  logic                      r_rsp_we;
  logic [LANES-1:0]          r_rsp_en;
  logic [LANES-1:0]          r_rsp_err;
  logic [LANES*DATA_W-1:0]   r_rsp_data;

  logic                      w_accept;
  logic                      w_last;
  logic                      w_commit;
  logic                      w_rsp_hs;
  logic [LANES-1:0]          w_err;
  logic [LANES*DATA_W-1:0]   w_rd_data;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == (r_we ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1)));
  assign w_commit = (r_state == S_WAIT) && w_last;
  assign w_rsp_hs = (r_state == S_RESP) && bus.rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and req_ready decode
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (w_last)        w_state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Per-lane range check and read lookup on the latched request
  always_comb begin
    w_err     = '0;
    w_rd_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_en[i]) begin
        if ({1'b0, r_addr[i*ADDR_W +: ADDR_W]} >= CMP_W'(DEPTH))
          w_err[i] = 1'b1;
        else
          w_rd_data[i*DATA_W +: DATA_W] = r_mem[MEM_AW'(r_addr[i*ADDR_W +: ADDR_W])];
      end
    end
  end

  // Request latch, latency counter, memory commit and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_en        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_en    <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) r_mem[d] <= '0;
    end else begin
      if (w_accept) begin
        r_we   <= bus.req_we;
        r_en   <= bus.req_en;
        r_addr <= bus.req_addr;
        r_data <= bus.req_data;
        r_cnt  <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end

      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_we    <= r_we;
        r_rsp_en    <= r_en;
        r_rsp_err   <= w_err;
        r_rsp_data  <= r_we ? '0 : w_rd_data;
        // Ascending lane order: the highest lane wins a shared address
        if (r_we) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (r_en[i] && !w_err[i])
              r_mem[MEM_AW'(r_addr[i*ADDR_W +: ADDR_W])] <= r_data[i*DATA_W +: DATA_W];
          end
        end
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_we    = r_rsp_we;
  assign bus.rsp_en    = r_rsp_en;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_lane_dram.sv
// Directed bench for lane_dram: a default instance (64 deep, 20/20 latency)
// and a small instance (48 deep, RD_LAT=3, WR_LAT=5) share one set of
// request drivers; sel picks which instance sees req_valid and is observed.
module tb_lane_dram;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        t_valid;
  logic        t_we;
  logic [7:0]  t_en;
  logic [47:0] t_addr;
  logic [63:0] t_data;
  logic        t_rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lane_dram_if #(.LANES(8), .DATA_W(8), .ADDR_W(6)) if0 ();
  lane_dram_if #(.LANES(8), .DATA_W(8), .ADDR_W(6)) if1 ();

  lane_dram u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  lane_dram #(.DEPTH(48), .RD_LAT(3), .WR_LAT(5)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  assign if0.req_valid = t_valid & ~sel;
  assign if1.req_valid = t_valid & sel;
  assign if0.req_we    = t_we;
  assign if1.req_we    = t_we;
  assign if0.req_en    = t_en;
  assign if1.req_en    = t_en;
  assign if0.req_addr  = t_addr;
  assign if1.req_addr  = t_addr;
  assign if0.req_data  = t_data;
  assign if1.req_data  = t_data;
  assign if0.rsp_ready = t_rsp_ready;
  assign if1.rsp_ready = t_rsp_ready;

  logic        o_ready, o_valid, o_we;
  logic [7:0]  o_en, o_err;
  logic [63:0] o_data;

  assign o_ready = sel ? if1.req_ready : if0.req_ready;
  assign o_valid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign o_we    = sel ? if1.rsp_we    : if0.rsp_we;
  assign o_en    = sel ? if1.rsp_en    : if0.rsp_en;
  assign o_err   = sel ? if1.rsp_err   : if0.rsp_err;
  assign o_data  = sel ? if1.rsp_data  : if0.rsp_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane i addresses word i
  function automatic logic [47:0] idx_addr();
    logic [47:0] a;
    for (int i = 0; i < 8; i++) a[i*6 +: 6] = 6'(i);
    return a;
  endfunction

  // One request with rsp_ready held high; checks latency, we and en echo
  task automatic txn(input string tag, input logic we, input logic [7:0] en,
                     input logic [47:0] addr, input logic [63:0] data, input int lat,
                     output logic [63:0] rdata, output logic [7:0] rerr);
    int cyc;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(o_ready), 64'd1);
    t_valid = 1'b1; t_we = we; t_en = en; t_addr = addr; t_data = data;
    t_rsp_ready = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    t_valid = 1'b0;
    while (!o_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lat + 1));
    check({tag, "_we"}, 64'(o_we), 64'(we));
    check({tag, "_en"}, 64'(o_en), 64'(en));
    rdata = o_data;
    rerr  = o_err;
    @(posedge clk);
  endtask

  initial begin
    logic [63:0] d, snap;
    logic [7:0]  e;
    logic [47:0] a;
    int          cyc, bad;

    reset = 1'b1; sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_en = '0;
    t_addr = '0; t_data = '0; t_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_we",    64'(o_we),    64'd0);
      check("rst_en",    64'(o_en),    64'd0);
      check("rst_err",   64'(o_err),   64'd0);
      check("rst_data",  o_data,       64'd0);
    end

    // Default instance: full write then read back
    sel = 1'b0;
    txn("basic_wr", 1'b1, 8'hFF, idx_addr(), 64'hA7A6_A5A4_A3A2_A1A0, 20, d, e);
    check("basic_wr_data", d, 64'd0);
    check("basic_wr_err",  64'(e), 64'd0);
    txn("basic_rd", 1'b0, 8'hFF, idx_addr(), 64'd0, 20, d, e);
    check("basic_rd_data", d, 64'hA7A6_A5A4_A3A2_A1A0);
    check("basic_rd_err",  64'(e), 64'd0);

    // Small instance: partial-enable write, read all lanes
    sel = 1'b1;
    txn("part_wr", 1'b1, 8'b0000_0101, idx_addr(), 64'h1716_1514_1312_1110, 5, d, e);
    check("part_wr_data", d, 64'd0);
    txn("part_rd", 1'b0, 8'hFF, idx_addr(), 64'd0, 3, d, e);
    check("part_rd_data", d, 64'h0000_0000_0012_0010);
    check("part_rd_err",  64'(e), 64'd0);

    // Lanes 1, 4, 6 write addr 5 with 11, 44, 66; lane 6 wins
    txn("conf_wr", 1'b1, 8'b0101_0010, {8{6'd5}}, 64'h0042_002C_0000_0B00, 5, d, e);
    txn("conf_rd", 1'b0, 8'b0000_0001, {8{6'd5}}, 64'd0, 3, d, e);
    check("conf_rd_data", d, 64'd66);

    // Lane 3 out of range at addr 50 (DEPTH 48); addr 2 must keep 8'h12
    a = '0; a[18 +: 6] = 6'd50;
    txn("oor_wr", 1'b1, 8'b0000_1000, a, 64'h0000_0000_FF00_0000, 5, d, e);
    check("oor_wr_err",  64'(e), 64'h08);
    check("oor_wr_data", d, 64'd0);
    txn("oor_rd", 1'b0, 8'b0000_1000, a, 64'd0, 3, d, e);
    check("oor_rd_err",  64'(e), 64'h08);
    check("oor_rd_data", d, 64'd0);
    a = '0; a[18 +: 6] = 6'd2;
    txn("oor_alias", 1'b0, 8'b0000_1000, a, 64'd0, 3, d, e);
    check("oor_alias_data", d, 64'h0000_0000_1200_0000);
    check("oor_alias_err",  64'(e), 64'd0);

    // Backpressure: rsp_ready low for 10 cycles, req_valid held high
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b0; t_en = 8'hFF; t_addr = idx_addr(); t_rsp_ready = 1'b0;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    while (!o_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_lat",  64'(cyc), 64'd4);
    snap = o_data;
    check("bp_data", snap, 64'h0000_4200_0012_0010);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!o_valid || o_ready || o_data !== snap || o_err !== 8'h00 ||
          o_en !== 8'hFF || o_we !== 1'b0) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    t_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 64'(o_ready), 64'd1);
    check("bp_idle_valid", 64'(o_valid), 64'd0);
    t_valid = 1'b0;
    @(negedge clk);
    check("bp_no_second", 64'(o_valid), 64'd0);

    // Reset five cycles into a default-instance write
    sel = 1'b0;
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b1; t_en = 8'h01; t_addr = {8{6'd7}}; t_data = 64'd77;
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_valid) bad++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_valid) bad++;
    end
    check("rstw_no_rsp", 64'(bad), 64'd0);
    txn("rstw_rd", 1'b0, 8'h01, {8{6'd7}}, 64'd0, 20, d, e);
    check("rstw_rd_data", d, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_dram.md
# lane_dram

Parametrised multi-lane DRAM behavioural model with a valid/ready request and response handshake, separate read and write latencies, and per-lane out-of-range error reporting. It sits behind the lane memory ports of the decode datapath and replaces the fixed 8-lane, 8-bit, 64-entry, 20-cycle memory model. One transaction is outstanding at a time; all enabled lanes share the same direction.

## Interface
- LANES, 8, number of independent lanes per transaction
- DATA_W, 8, bits per lane word
- ADDR_W, 6, bits per lane address
- DEPTH, 64, number of words; legal range 1..2**ADDR_W
- RD_LAT, 20, cycles from request acceptance to read response; minimum 1
- WR_LAT, 20, cycles from request acceptance to write response; minimum 1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  model can accept a request
- req_we  in  1  1 = write, 0 = read
- req_en  in  LANES  per-lane enable
- req_addr  in  LANES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W]
- req_data  in  LANES*DATA_W  write data for lane i
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_we  out  1  copy of the accepted req_we
- rsp_en  out  LANES  copy of the accepted req_en
- rsp_err  out  LANES  lane address >= DEPTH (only for enabled lanes)
- rsp_data  out  LANES*DATA_W  read data; 0 for writes, disabled lanes, and errored lanes

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid && req_ready. The model latches we, en, addr, and data, clears cnt, and moves to WAIT.
- A request with req_en=0 is still accepted and completes normally with an all-zero response.
- WAIT:
  - req_ready=0.
  - cnt increments each cycle. cnt is $clog2(max(RD_LAT,WR_LAT))+1 bits wide.
  - When cnt == LAT-1, where LAT = we ? WR_LAT : RD_LAT, the model goes to RESP.
  - On that same edge it commits writes for enabled in-range lanes, and captures read data for enabled in-range lanes from memory state before this edge.
- Write conflicts: when several enabled lanes write the same address, the highest lane index wins.
- Out-of-range lanes (addr >= DEPTH):
  - A write is dropped.
  - A read returns 0.
  - rsp_err[i]=1 in both cases.
- RESP:
  - rsp_valid=1 and all rsp_* outputs are held stable until rsp_ready=1.
  - On the rsp_valid && rsp_ready edge the model returns to IDLE.
  - req_ready is not asserted in the same cycle, so there is no bypass.
- Memory is zeroed on reset.
- Reset mid-transaction:
  - The transaction is discarded.
  - State returns to IDLE.
  - An uncommitted write never reaches memory.

## Timing
- Reset values:
  - req_ready=1 from the first cycle after reset.
  - rsp_valid=0; rsp_we, rsp_en, rsp_err, rsp_data all 0.
  - cnt=0.
- Latency: a request accepted at edge T yields rsp_valid=1 in the cycle after edge T+LAT, with WAIT occupying LAT cycles.
- RD_LAT=1 or WR_LAT=1 gives exactly one WAIT cycle.
- Throughput: at most one transaction per LAT+2 cycles when rsp_ready is tied high.
- A write that commits at edge T+LAT is visible to a read accepted at any later edge.
- req_* inputs are ignored outside IDLE and may change freely.
- rsp_ready is ignored outside RESP.
- All outputs are registered except req_ready, which is a decode of state==IDLE.

## Test plan
- Write/read basic, defaults:
  - Stimulus: write lanes 0-7 at addr i, data 8'hA0+i; then read the same addresses.
  - Required: rsp_valid 21 cycles after each accept; read rsp_data lane i = 8'hA0+i; rsp_err=0.
- Partial enable and latencies, RD_LAT=3, WR_LAT=5:
  - Stimulus: write with en=8'b0000_0101, then read all lanes.
  - Required: write response at +6, read response at +4; only lanes 0 and 2 hold the new data; other lanes read 0.
- Conflict:
  - Stimulus: lanes 1, 4, 6 write addr 5 with 11, 44, 66.
  - Required: a later read of addr 5 returns 66.
- Out of range, DEPTH=48:
  - Stimulus: lane 3 writes addr 50 with 8'hFF, then reads addr 50.
  - Required: rsp_err=8'b0000_1000 on both responses; read data 0; memory at addr 50 mod 48 is unchanged.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles during RESP; drive req_valid high throughout.
  - Required: rsp_* stable, req_ready=0, no second accept; IDLE is entered on the cycle after rsp_ready=1.
- Reset mid-WAIT:
  - Stimulus: assert reset 5 cycles into a write, release, then read the same address.
  - Required: rsp_valid never fires for the write; the read returns 0.
